iddmm_result_sel: RTL and testbench
===================================

Name: iddmm_result_sel

Overview:
- Downstream neighbour of the IDDMM calculation core.
- Captures the core's two candidate result streams: raw result words A, and A−P words SUB, K bits each, N words per operation.
- On the core's done pulse, latches the final-subtraction decision (sign).
- Streams the selected N-word Montgomery product out least-significant word first, with a valid/ready handshake and a last-word marker.

Parameters:
- K, 128, bits per word.
- N, 32, words per operand/result.
- DEPTH, 2*N, words per internal FIFO; allows the next operation's writes to overlap the current drain.
- ADDR_W, $clog2(DEPTH), FIFO pointer width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- fifo_wr_en_a  in  1  write strobe for a raw result word.
- fifo_wr_data_a  in  K  raw result word A[j].
- fifo_wr_en_sub  in  1  write strobe for a subtracted word.
- fifo_wr_data_sub  in  K  word (A−P)[j].
- cal_done  in  1  one-cycle pulse: operation finished.
- cal_sign  in  1  valid with cal_done; 1 = output SUB words, 0 = output A words.
- o_valid  out  1  output word valid.
- o_data  out  K  selected result word.
- o_last  out  1  high with word N−1.
- i_ready  in  1  downstream accepts.
- busy  out  1  state != IDLE.
- err  out  1  sticky error: overflow, underflow, or double-pending done.

Behaviour:
- Reset: one clock, synchronous active-low; rst_n sampled at posedge clk. While low, at each edge:
  - FIFOs emptied; word counter = 0; state = IDLE.
  - pend = 0; sign_q = 0.
  - Outputs: o_valid = 0, o_data = 0, o_last = 0, busy = 0, err = 0.
  - Reset mid-drain abandons the operation; no partial words are emitted after rst_n deasserts.
- FIFOs: two identical first-word-fall-through sync FIFOs, A and SUB.
  - Each write is accepted on a rising edge when its wr_en = 1 and the FIFO is not full.
  - Write to a full FIFO: word dropped, err set.
  - Writes are accepted in every state.
- Done capture:
  - cal_done = 1 sets pend = 1 and sign_pend = cal_sign.
  - cal_done while pend is already 1: err set; the new sign overwrites.
  - cal_done may coincide with the final SUB write; that write is counted before the level check below.
- States:
  - IDLE: if pend and both FIFO levels >= N, go to DRAIN next edge. On that edge sign_q <= sign_pend, pend <= 0, cnt <= 0.
  - IDLE: if pend and either level < N for 4*N consecutive cycles, set err, clear pend, and stay in IDLE (timeout underflow).
  - DRAIN: o_valid = 1.
    - o_data = sign_q ? SUB head : A head (combinational from FIFO heads, no extra register).
    - o_last = (cnt == N−1).
    - On o_valid & i_ready: pop both FIFOs together; cnt++.
    - On o_valid & i_ready & o_last: go to IDLE.
  - o_data, o_valid and o_last hold stable while i_ready = 0.
- Latency (ideal case: levels already >= N, i_ready held 1):
  - cal_done at edge t → pend visible in cycle t+1 → DRAIN entered at edge t+1 → o_valid high from cycle t+2.
  - N words in N consecutive cycles.
- Simultaneity:
  - A new cal_done arriving during DRAIN sets pend. The next operation starts directly after o_last is accepted, with exactly one IDLE cycle between.
  - A pop and a write to the same FIFO in the same cycle: level unchanged, both take effect.
- Arithmetic: FIFO levels are ADDR_W+1 bits; pointers wrap modulo DEPTH. No data arithmetic is performed.

Decomposition:
- iddmm_pkg holds:
  - the default K and N localparams;
  - the state enum typedef (IDLE, DRAIN);
  - the timeout constant 4*N.
- One sub-module, iddmm_sync_fifo (width K, depth DEPTH, FWFT, synchronous active-low reset, outputs full/empty/level), instantiated twice.

Test Plan:
- Reset, then 32 A words 0x1..0x20 and 32 SUB words 0x101..0x120; cal_done with cal_sign = 1, i_ready = 1 → o_valid from the 2nd cycle after cal_done; o_data 0x101..0x120 in consecutive cycles; o_last only on 0x120; busy drops the cycle after; err = 0.
- Same streams with cal_sign = 0, i_ready toggling 1/0 each cycle → o_data = 0x1..0x20, each value held stable while i_ready = 0; 32 handshakes total.
- Back-to-back operations: the second operation's writes and cal_done (sign 1) arrive during the first drain (sign 0) → first emits A words, then exactly one idle cycle, then second emits SUB words; err = 0.
- cal_done after only 31 SUB words → no o_valid; after 128 cycles err = 1, state IDLE, pend = 0.
- 65 A writes with no drain → 65th word dropped, err = 1; a later drain of sign 0 emits only the first 32 words.
- rst_n low for one cycle at drain word 10 → o_valid = 0 and busy = 0 the next cycle, FIFOs empty; a fresh operation afterwards completes correctly.

Source files
------------

// File: rtl/iddmm_pkg.sv
// Shared types and constants for the IDDMM result selector.
package iddmm_pkg;

  localparam int unsigned DefaultK    = 128;
  localparam int unsigned DefaultN    = 32;
  localparam int unsigned TimeoutMult = 4;

  typedef enum logic {
    StIdle,
    StDrain
  } state_e;

  // Cycles a pending done may wait for both FIFOs to reach N words.
  function automatic int unsigned timeout_cycles(input int unsigned n);
    return TimeoutMult * n;
  endfunction

endpackage

// File: rtl/iddmm_sync_fifo.sv
// First-word-fall-through synchronous FIFO with level output.
module iddmm_sync_fifo #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW:0]   level_o
);

  localparam int unsigned LvlW = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   level_q;
  logic             wr_ok, rd_ok;

  assign full_o    = (level_q == LvlW'(Depth));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_ok     = wr_en_i & ~full_o;
  assign rd_ok     = rd_en_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= (wr_ptr_q == AddrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q <= (rd_ptr_q == AddrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/iddmm_result_sel.sv
// Buffers the core's A and A-P word streams and drains the selected N-word
// Montgomery product LSW first once the final-subtraction sign is known.
module iddmm_result_sel
  import iddmm_pkg::*;
#(
  parameter int unsigned K      = DefaultK,
  parameter int unsigned N      = DefaultN,
  parameter int unsigned DEPTH  = 2 * N,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fifo_wr_en_a,
  input  logic [K-1:0] fifo_wr_data_a,
  input  logic         fifo_wr_en_sub,
  input  logic [K-1:0] fifo_wr_data_sub,
  input  logic         cal_done,
  input  logic         cal_sign,
  output logic         o_valid,
  output logic [K-1:0] o_data,
  output logic         o_last,
  input  logic         i_ready,
  output logic         busy,
  output logic         err
);

  localparam int unsigned LvlW    = ADDR_W + 1;
  localparam int unsigned CntW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TmoLim  = timeout_cycles(N);
  localparam int unsigned TmoW    = $clog2(TmoLim);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [TmoW-1:0]   tmo_q;
  logic              pend_q, sign_pend_q, sign_q, err_q;

  logic [K-1:0]      head_a, head_sub;
  logic              full_a, full_sub, empty_a, empty_sub;
  logic [ADDR_W:0]   level_a, level_sub;
  logic              pop, lvl_ok, tmo_hit, consume;

  iddmm_sync_fifo #(
    .Width (K),
    .Depth (DEPTH),
    .AddrW (ADDR_W)
  ) u_fifo_a (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (fifo_wr_en_a),
    .wr_data_i (fifo_wr_data_a),
    .rd_en_i   (pop),
    .rd_data_o (head_a),
    .full_o    (full_a),
    .empty_o   (empty_a),
    .level_o   (level_a)
  );

  iddmm_sync_fifo #(
    .Width (K),
    .Depth (DEPTH),
    .AddrW (ADDR_W)
  ) u_fifo_sub (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (fifo_wr_en_sub),
    .wr_data_i (fifo_wr_data_sub),
    .rd_en_i   (pop),
    .rd_data_o (head_sub),
    .full_o    (full_sub),
    .empty_o   (empty_sub),
    .level_o   (level_sub)
  );

  assign o_valid = (state_q == StDrain);
  assign o_data  = o_valid ? (sign_q ? head_sub : head_a) : '0;
  assign o_last  = o_valid && (cnt_q == CntW'(N - 1));
  assign busy    = (state_q != StIdle);
  assign err     = err_q;
  assign pop     = o_valid & i_ready;

  assign lvl_ok  = (level_a >= LvlW'(N)) && (level_sub >= LvlW'(N));
  assign tmo_hit = (tmo_q == TmoW'(TmoLim - 1));
  // The pending done is retired this cycle, either by starting a drain or timing out.
  assign consume = (state_q == StIdle) && pend_q && (lvl_ok || tmo_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tmo_q       <= '0;
      pend_q      <= 1'b0;
      sign_pend_q <= 1'b0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if ((fifo_wr_en_a && full_a) || (fifo_wr_en_sub && full_sub) ||
          (pop && (empty_a || empty_sub))) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (pend_q && lvl_ok) begin
            state_q <= StDrain;
            sign_q  <= sign_pend_q;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
          end else if (pend_q) begin
            if (tmo_hit) begin
              err_q  <= 1'b1;
              pend_q <= 1'b0;
              tmo_q  <= '0;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end else begin
            tmo_q <= '0;
          end
        end
        StDrain: begin
          if (pop) begin
            cnt_q <= cnt_q + 1'b1;
            if (o_last) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // A new done overrides any retirement above; a still-pending one is an error.
      if (cal_done) begin
        if (pend_q && !consume) begin
          err_q <= 1'b1;
        end
        pend_q      <= 1'b1;
        sign_pend_q <= cal_sign;
        tmo_q       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iddmm_result_sel.sv
// Directed bench for iddmm_result_sel: table-driven drains plus corner sequences.
module tb_iddmm_result_sel;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_wr_en_a, fifo_wr_en_sub;
  logic [127:0] fifo_wr_data_a, fifo_wr_data_sub;
  logic         cal_done, cal_sign;
  logic         o_valid, o_last, i_ready, busy, err;
  logic [127:0] o_data;

  int n_tests = 0;
  int n_fail  = 0;

  iddmm_result_sel dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fifo_wr_en_a     (fifo_wr_en_a),
    .fifo_wr_data_a   (fifo_wr_data_a),
    .fifo_wr_en_sub   (fifo_wr_en_sub),
    .fifo_wr_data_sub (fifo_wr_data_sub),
    .cal_done         (cal_done),
    .cal_sign         (cal_sign),
    .o_valid          (o_valid),
    .o_data           (o_data),
    .o_last           (o_last),
    .i_ready          (i_ready),
    .busy             (busy),
    .err              (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d",
             n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit           sign;
    bit           toggle;
    logic [127:0] a_base;
    logic [127:0] sub_base;
    logic [127:0] exp_base;
  } vec_t;

  vec_t tbl [3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_wr_en_a = 0; fifo_wr_en_sub = 0;
    fifo_wr_data_a = '0; fifo_wr_data_sub = '0;
    cal_done = 0; cal_sign = 0; i_ready = 1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic write_words(input logic [127:0] a_base, input int na,
                             input logic [127:0] s_base, input int ns);
    int n = (na > ns) ? na : ns;
    for (int j = 0; j < n; j++) begin
      fifo_wr_en_a     = (j < na);
      fifo_wr_data_a   = a_base + 128'(j);
      fifo_wr_en_sub   = (j < ns);
      fifo_wr_data_sub = s_base + 128'(j);
      step();
    end
    fifo_wr_en_a = 0;
    fifo_wr_en_sub = 0;
  endtask

  task automatic pulse_done(input bit sign);
    cal_done = 1'b1;
    cal_sign = sign;
    step();
    cal_done = 1'b0;
    cal_sign = 1'b0;
  endtask

  // Collects 32 handshakes starting in the current (valid) cycle.
  task automatic drain(input logic [127:0] base, input bit toggle, input string tag,
                       output int cycles);
    int got = 0;
    int cyc = 0;
    bit held = 0;
    logic [127:0] hv = '0;
    while (got < 32 && cyc < 300) begin
      i_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (held) begin
        chk({tag, " hold_data"}, o_data, hv);
        chk({tag, " hold_valid"}, o_valid, 1);
        held = 0;
      end
      if (o_valid && i_ready) begin
        chk({tag, " data"}, o_data, base + 128'(got));
        chk({tag, " last"}, o_last, (got == 31));
        got++;
      end else if (o_valid) begin
        held = 1;
        hv = o_data;
      end
      cyc++;
      step();
    end
    i_ready = 1'b1;
    if (got < 32) chk({tag, " handshakes"}, got, 32);
    chk({tag, " busy_after"}, busy, 0);
    cycles = cyc;
  endtask

  initial begin
    int cyc;
    bit seen;

    tbl[0] = '{sign: 1, toggle: 0, a_base: 128'h1, sub_base: 128'h101, exp_base: 128'h101};
    tbl[1] = '{sign: 0, toggle: 1, a_base: 128'h1, sub_base: 128'h101, exp_base: 128'h1};
    tbl[2] = '{sign: 1, toggle: 1, a_base: 128'hA000, sub_base: 128'hB000,
               exp_base: 128'hB000};

    do_reset();
    chk("rst o_valid", o_valid, 0);
    chk("rst o_data", o_data, 0);
    chk("rst o_last", o_last, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);

    for (int i = 0; i < 3; i++) begin
      write_words(tbl[i].a_base, 32, tbl[i].sub_base, 32);
      pulse_done(tbl[i].sign);
      chk($sformatf("v%0d lat_t1", i), o_valid, 0);
      step();
      chk($sformatf("v%0d lat_t2", i), o_valid, 1);
      drain(tbl[i].exp_base, tbl[i].toggle, $sformatf("v%0d", i), cyc);
      if (!tbl[i].toggle) chk($sformatf("v%0d cycles", i), cyc, 32);
      chk($sformatf("v%0d err", i), err, 0);
    end

    // Back-to-back: second op's words and done arrive during the first drain.
    write_words(128'h1, 32, 128'h101, 32);
    pulse_done(1'b0);
    step();
    chk("b2b first_valid", o_valid, 1);
    fork
      drain(128'h1, 1'b1, "b2b op1", cyc);
      begin
        write_words(128'h201, 32, 128'h301, 32);
        pulse_done(1'b1);
      end
    join
    step();
    chk("b2b second_valid", o_valid, 1);
    drain(128'h301, 1'b0, "b2b op2", cyc);
    chk("b2b op2 cycles", cyc, 32);
    chk("b2b err", err, 0);

    // Underflow timeout: only 31 SUB words.
    do_reset();
    write_words(128'h1, 32, 128'h101, 31);
    pulse_done(1'b1);
    seen = 0;
    for (int j = 0; j < 127; j++) begin
      seen |= o_valid;
      step();
    end
    chk("tmo no_valid", seen, 0);
    chk("tmo err_before", err, 0);
    step();
    chk("tmo err_after", err, 1);
    chk("tmo busy", busy, 0);
    write_words(128'h120, 0, 128'h120, 1);
    seen = 0;
    for (int j = 0; j < 6; j++) begin
      seen |= o_valid;
      step();
    end
    chk("tmo pend_cleared", seen, 0);

    // Overflow: 65th A word dropped.
    do_reset();
    write_words(128'h1, 64, 128'h101, 32);
    chk("ovf err_before", err, 0);
    write_words(128'h41, 1, 128'h0, 0);
    chk("ovf err_after", err, 1);
    pulse_done(1'b0);
    step();
    chk("ovf valid", o_valid, 1);
    drain(128'h1, 1'b0, "ovf op1", cyc);
    write_words(128'h0, 0, 128'h121, 32);
    pulse_done(1'b0);
    step();
    chk("ovf valid2", o_valid, 1);
    drain(128'h21, 1'b0, "ovf op2", cyc);

    // Reset in the middle of a drain.
    do_reset();
    write_words(128'h1, 32, 128'h101, 32);
    pulse_done(1'b1);
    step();
    for (int w = 0; w < 10; w++) begin
      chk("mid data", o_data, 128'h101 + 128'(w));
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid o_valid", o_valid, 0);
    chk("mid busy", busy, 0);
    chk("mid o_data", o_data, 0);
    chk("mid err", err, 0);
    seen = 0;
    for (int j = 0; j < 4; j++) begin
      seen |= o_valid;
      step();
    end
    chk("mid no_partial", seen, 0);
    write_words(128'h501, 32, 128'h601, 32);
    pulse_done(1'b0);
    step();
    chk("mid fresh_valid", o_valid, 1);
    drain(128'h501, 1'b0, "mid fresh", cyc);
    chk("mid fresh cycles", cyc, 32);
    chk("mid fresh err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
